dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum host accesses per host tenure (legal range 1..15).
REQ-002 Parameter STARVE_LIM, default 8: host-wait cycles, while the core is busy, before host is forced in (legal range 1..15).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 core_req  in  1  core needs memory this cycle (MemRead|MemWrite).
REQ-006 core_we  in  1  core write enable (MemWrite).
REQ-007 core_addr  in  8  core address (ALU result).
REQ-008 core_wdat  in  8  core store data.
REQ-009 core_rdat  out  8  core load data.
REQ-010 core_stall  out  1  core must hold PC and suppress RegWrite this cycle.
REQ-011 host_req  in  1  host (testbench loader/readback) access request.
REQ-012 host_we  in  1  host write enable.
REQ-013 host_addr  in  8  host address.
REQ-014 host_wdat  in  8  host write data.
REQ-015 host_gnt  out  1  host access performed this cycle.
REQ-016 host_rvalid  out  1  host read data valid (one-cycle pulse).
REQ-017 host_rdat  out  8  host read data.
REQ-018 mem_addr  out  8;  mem_wr_en  out  1;  mem_dat_in  out  8  to dat_mem port.
REQ-019 mem_dat_out  in  8  combinational read data from dat_mem.

Function
REQ-020 Two states: CORE (core owns port, default) and HOST (host owns port).
REQ-021 In CORE: mem_addr/mem_dat_in = core_addr/core_wdat; mem_wr_en = core_req & core_we; core_stall = 0; host_gnt = 0.
REQ-022 In HOST: mem port driven from host_* ; mem_wr_en = host_req & host_we; host_gnt = host_req; core_stall = core_req.
REQ-023 core_rdat = mem_dat_out combinationally in all states (valid only when core_stall = 0).
REQ-024 starve_cnt (4 bits): in CORE, increments when host_req & core_req; clears when host_req = 0 and on entry to HOST.
REQ-025 CORE -> HOST next cycle when host_req & (!core_req | starve_cnt == STARVE_LIM-1).
REQ-026 beat_cnt (4 bits): cleared on entry to HOST; increments on each host_gnt.
REQ-027 HOST -> CORE next cycle when host_req = 0, or when host_gnt & beat_cnt == MAX_BURST-1.
REQ-028 After leaving HOST, CORE is held at least one cycle (no re-entry to HOST in the exit cycle's successor), guaranteeing core progress.
REQ-029 Host read latency 1: on host_gnt & !host_we, host_rdat <= mem_dat_out and host_rvalid = 1 on the following cycle; otherwise host_rvalid = 0, host_rdat holds.
REQ-030 Host writes complete in the host_gnt cycle; no response pulse.
REQ-031 Host must hold request fields stable until host_gnt; arbiter never grants a beat it does not perform.
REQ-032 Counters saturate at 15; never wrap.

Reset
REQ-033 On reset: state = CORE, starve_cnt = 0, beat_cnt = 0, host_rvalid = 0, host_rdat = 8'h00; effective the cycle after reset is sampled high.
REQ-034 Reset asserted mid-HOST aborts the tenure; any pending read response is dropped (host_rvalid = 0).

Structure
REQ-035 Shared package arb_pkg holds the state enum (CORE, HOST) and counter-width constant (4).
REQ-036 No sub-module; a single always_ff for state/counters/response and one always_comb for port muxing.

Verification
REQ-037 Reset then idle core, host writes 8'hA5 to addr 8'h10 -> HOST entered next cycle, host_gnt=1, mem_wr_en=1, mem_addr=8'h10.
REQ-038 Host read addr 8'h10 after REQ-037 write -> host_rvalid=1 one cycle after host_gnt, host_rdat=8'hA5.
REQ-039 core_req held high continuously, host_req raised -> HOST entered exactly STARVE_LIM cycles later, core_stall=1 throughout HOST.
REQ-040 Host holds host_req for 10 beats, MAX_BURST=4 -> grants in groups of 4, each separated by >=1 CORE cycle with core_stall=0.
REQ-041 Reset asserted during a HOST read -> next cycle state=CORE, host_rvalid=0, core_stall=0.
REQ-042 Simultaneous core store (addr 8'h20, 8'h3C) and host request with starve_cnt=0 -> core write performed first, host_gnt=0 that cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package arb_pkg;

  // Width of the starvation and burst counters.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Port ownership: the core owns the memory port by default.
  typedef enum logic {
    CORE = 1'b0,
    HOST = 1'b1
  } arb_state_t;

  // Saturating increment so the counters stick at their maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dm_arbiter.sv
// Arbitrates a single data-memory port between the processor core and a host
// loader/readback agent. The core is preferred; the host gets in when the core
// is idle or after waiting STARVE_LIM cycles, and is limited to MAX_BURST
// accesses per tenure before the port is returned to the core.
module dm_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BURST  = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic       clk,
  input  logic       reset,
  // core side
  input  logic       core_req,
  input  logic       core_we,
  input  logic [7:0] core_addr,
  input  logic [7:0] core_wdat,
  output logic [7:0] core_rdat,
  output logic       core_stall,
  // host side
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdat,
  output logic       host_gnt,
  output logic       host_rvalid,
  output logic [7:0] host_rdat,
  // memory port
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_dat_in,
  input  logic [7:0] mem_dat_out
);

  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIM - 1);
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(MAX_BURST - 1);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_host_rvalid;
  logic [7:0]       r_host_rdat;

  logic             w_host_gnt;
  logic             w_to_host;
  logic             w_to_core;

  // Port muxing by owner, plus the ownership-change decisions for this cycle.
  always_comb begin
    mem_addr   = core_addr;
    mem_dat_in = core_wdat;
    mem_wr_en  = core_req & core_we;
    core_stall = 1'b0;
    core_rdat  = mem_dat_out;
    w_host_gnt = 1'b0;
    w_to_host  = 1'b0;
    w_to_core  = 1'b0;
    case (r_state)
      CORE: begin
        // An idle core yields at once; a busy one only once the host has starved long enough.
        w_to_host = host_req & (~core_req | (r_starve_cnt == STARVE_LAST));
      end
      HOST: begin
        mem_addr   = host_addr;
        mem_dat_in = host_wdat;
        mem_wr_en  = host_req & host_we;
        w_host_gnt = host_req;
        core_stall = core_req;
        // Return the port when the host is done or has used its whole burst.
        // The transition is registered, so the core always gets at least one
        // cycle of ownership before the host can come back.
        w_to_core  = ~host_req | (w_host_gnt & (r_beat_cnt == BURST_LAST));
      end
      default: ;
    endcase
  end

  assign host_gnt    = w_host_gnt;
  assign host_rvalid = r_host_rvalid;
  assign host_rdat   = r_host_rdat;

  // Ownership state, starvation/burst counters and the host read response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= CORE;
      r_starve_cnt  <= '0;
      r_beat_cnt    <= '0;
      r_host_rvalid <= 1'b0;
      r_host_rdat   <= 8'h00;
    end else begin
      r_host_rvalid <= w_host_gnt & ~host_we;
      if (w_host_gnt & ~host_we) begin
        r_host_rdat <= mem_dat_out;
      end
      case (r_state)
        CORE: begin
          if (w_to_host) begin
            r_state      <= HOST;
            r_starve_cnt <= '0;
            r_beat_cnt   <= '0;
          end else if (~host_req) begin
            r_starve_cnt <= '0;
          end else if (core_req) begin
            r_starve_cnt <= sat_inc(r_starve_cnt);
          end
        end
        HOST: begin
          if (w_host_gnt) begin
            r_beat_cnt <= sat_inc(r_beat_cnt);
          end
          if (w_to_core) begin
            r_state <= CORE;
          end
        end
        default: r_state <= CORE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural data memory attached.
module tb_dm_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdat, core_rdat;
  logic       core_stall;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdat;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdat;
  logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
  logic       mem_wr_en;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  dm_arbiter #(.MAX_BURST(4), .STARVE_LIM(8)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdat(core_wdat), .core_rdat(core_rdat), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdat(host_wdat), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdat(host_rdat),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_dat_in(mem_dat_in),
    .mem_dat_out(mem_dat_out)
  );

  // Data memory: combinational read, write on the clock edge.
  assign mem_dat_out = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [12:0] exp_gnt;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdat = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdat = 8'h00;
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rvalid", {7'd0, host_rvalid}, 8'h00);
    chk("rst_rdat", host_rdat, 8'h00);
    chk("rst_gnt", {7'd0, host_gnt}, 8'h00);
    chk("rst_stall", {7'd0, core_stall}, 8'h00);
    $display("reset state checked");

    // Host write A5 to 10 with idle core: no grant in the request cycle
    next_cycle();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdat = 8'hA5;
    @(negedge clk);
    chk("wr_req_gnt", {7'd0, host_gnt}, 8'h00);
    chk("wr_req_wren", {7'd0, mem_wr_en}, 8'h00);
    // HOST entered next cycle, write performed
    next_cycle();
    @(negedge clk);
    chk("wr_gnt", {7'd0, host_gnt}, 8'h01);
    chk("wr_wren", {7'd0, mem_wr_en}, 8'h01);
    chk("wr_addr", mem_addr, 8'h10);
    chk("wr_data", mem_dat_in, 8'hA5);
    $display("host write addr=10 data=A5 gnt=%b", host_gnt);

    // Host read of 10 in the same tenure
    next_cycle();
    host_we = 1'b0;
    @(negedge clk);
    chk("rd_gnt", {7'd0, host_gnt}, 8'h01);
    chk("rd_wren", {7'd0, mem_wr_en}, 8'h00);
    next_cycle();
    host_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", {7'd0, host_rvalid}, 8'h01);
    chk("rd_rdat", host_rdat, 8'hA5);
    chk("rd_idle_gnt", {7'd0, host_gnt}, 8'h00);
    $display("host read addr=10 rvalid=%b rdat=%h", host_rvalid, host_rdat);

    // Back in CORE: response pulse over, data held. Simultaneous core store and host request.
    next_cycle();
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h20; core_wdat = 8'h3C;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    @(negedge clk);
    chk("post_rvalid", {7'd0, host_rvalid}, 8'h00);
    chk("post_rdat_hold", host_rdat, 8'hA5);
    chk("coll_gnt", {7'd0, host_gnt}, 8'h00);
    chk("coll_wren", {7'd0, mem_wr_en}, 8'h01);
    chk("coll_addr", mem_addr, 8'h20);
    chk("coll_data", mem_dat_in, 8'h3C);
    chk("coll_stall", {7'd0, core_stall}, 8'h00);
    $display("core store addr=20 data=3C with host pending gnt=%b", host_gnt);

    // Busy core: host waits STARVE_LIM (8) cycles in total before entering
    for (int i = 1; i < 8; i++) begin
      next_cycle();
      core_we = 1'b0;
      @(negedge clk);
      chk("starve_gnt", {7'd0, host_gnt}, 8'h00);
      chk("starve_stall", {7'd0, core_stall}, 8'h00);
    end
    next_cycle();
    @(negedge clk);
    chk("forced_gnt", {7'd0, host_gnt}, 8'h01);
    chk("forced_stall", {7'd0, core_stall}, 8'h01);
    $display("host forced in after 8 wait cycles gnt=%b stall=%b", host_gnt, core_stall);
    // Remaining beats of this burst: stall throughout, read returns the core's store
    for (int i = 1; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      chk("burst1_gnt", {7'd0, host_gnt}, 8'h01);
      chk("burst1_stall", {7'd0, core_stall}, 8'h01);
      if (i == 1) chk("core_store_rdat", host_rdat, 8'h3C);
    end
    // Burst limit reached: port returns to the core
    next_cycle();
    @(negedge clk);
    chk("burst1_exit_gnt", {7'd0, host_gnt}, 8'h00);
    chk("burst1_exit_stall", {7'd0, core_stall}, 8'h00);
    $display("burst of 4 ended, core owns port");

    // Idle core, host holds request for 10 beats: groups of 4,4,2 with a CORE cycle between
    exp_gnt = 13'b1101111011110;
    begin
      int grants;
      grants = 0;
      for (int i = 0; i < 13; i++) begin
        next_cycle();
        core_req = 1'b0;
        host_addr = 8'h10;
        @(negedge clk);
        chk("burst_gnt", {7'd0, host_gnt}, {7'd0, exp_gnt[i]});
        chk("burst_stall", {7'd0, core_stall}, 8'h00);
        if (host_gnt) grants++;
        $display("burst cycle %0d gnt=%b grants=%0d", i, host_gnt, grants);
      end
      chk("burst_total", 8'(grants), 8'd10);
    end
    next_cycle();
    host_req = 1'b0;
    @(negedge clk);
    chk("burst_last_rvalid", {7'd0, host_rvalid}, 8'h01);
    chk("burst_last_rdat", host_rdat, 8'hA5);

    // Reset during a HOST read aborts the tenure and drops the response
    next_cycle();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    @(negedge clk);
    chk("abort_req_gnt", {7'd0, host_gnt}, 8'h00);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_host_gnt", {7'd0, host_gnt}, 8'h01);
    next_cycle();
    reset = 1'b0;
    core_req = 1'b1;
    @(negedge clk);
    chk("abort_gnt", {7'd0, host_gnt}, 8'h00);
    chk("abort_rvalid", {7'd0, host_rvalid}, 8'h00);
    chk("abort_stall", {7'd0, core_stall}, 8'h00);
    chk("abort_rdat", host_rdat, 8'h00);
    $display("reset mid-read: gnt=%b rvalid=%b stall=%b", host_gnt, host_rvalid, core_stall);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
